// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: mem_op encoding,
// latched memory request bundle and op-class helpers.
package mips_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wb_en;
    logic [4:0]  wb_addr;
  } mem_req_t;

  function automatic logic is_load(
    input logic [3:0] op
  );
    return (op >= MEM_LB) && (op <= MEM_LW);
  endfunction

  function automatic logic is_store(
    input logic [3:0] op
  );
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  function automatic logic misaligned(
    input logic [3:0] op,
    input logic [1:0] a
  );
    logic half, word;
    half = (op == MEM_LH) || (op == MEM_LHU)
        || (op == MEM_SH);
    word = (op == MEM_LW) || (op == MEM_SW);
    return (half && a[0]) || (word && (a != 2'b00));
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select with sign/zero extension.
// Ports: op/lane select the field of rdata; data is the result.
module load_align
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{lane, 3'b000} +: 8];
    h    = lane[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    unique case (1'b1)
      op == MEM_LB:  data = {{24{b[7]}}, b};
      op == MEM_LBU: data = {24'h0, b};
      op == MEM_LH:  data = {{16{h[15]}}, h};
      op == MEM_LHU: data = {16'h0, h};
      default:       data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MIPS memory-access stage: req/ack data-memory port, MEM/WB bundle.
// Ports: EX inputs (in_valid/in_ready), dmem_* bus, registered WB outputs.
module mem_access
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [3:0]  mem_op,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_addr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        out_valid,
  output logic [31:0] wb_data,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic        exc_misalign,
  output logic        exc_bus
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;

  // Last count value before the bus error fires: req is
  // held for exactly TIMEOUT cycles without ack.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic        state;
  mem_req_t    req_q;
  logic [15:0] cnt;
  logic        acc;
  logic        st_q;
  logic [31:0] ld_data;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  assign acc      = (state == ST_ACCESS);
  assign in_ready = (state == ST_IDLE);
  assign st_q     = is_store(req_q.op);

  load_align u_load_align (
    .op    (req_q.op),
    .lane  (req_q.addr[1:0]),
    .rdata (dmem_rdata),
    .data  (ld_data)
  );

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_q.data;
    unique case (1'b1)
      req_q.op == MEM_SB: begin
        st_be    = 4'b0001 << req_q.addr[1:0];
        st_wdata = {4{req_q.data[7:0]}};
      end
      req_q.op == MEM_SH: begin
        st_be    = req_q.addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{req_q.data[15:0]}};
      end
      default: ;
    endcase
  end

  assign dmem_req   = acc;
  assign dmem_we    = acc && st_q;
  assign dmem_addr  = acc ? {req_q.addr[31:2], 2'b00} : 32'h0;
  assign dmem_be    = acc ? st_be : 4'h0;
  assign dmem_wdata = (acc && st_q) ? st_wdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_q        <= '0;
      cnt          <= '0;
      out_valid    <= 1'b0;
      wb_data      <= '0;
      wb_en        <= 1'b0;
      wb_addr      <= '0;
      exc_misalign <= 1'b0;
      exc_bus      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_load(mem_op) && !is_store(mem_op)) begin
              out_valid    <= 1'b1;
              wb_data      <= alu_result;
              wb_en        <= wb_en_in;
              wb_addr      <= wb_addr_in;
              exc_misalign <= 1'b0;
              exc_bus      <= 1'b0;
            end else if (misaligned(mem_op, alu_result[1:0])) begin
              out_valid    <= 1'b1;
              wb_data      <= alu_result;
              wb_en        <= 1'b0;
              wb_addr      <= wb_addr_in;
              exc_misalign <= 1'b1;
              exc_bus      <= 1'b0;
            end else begin
              req_q <= '{op:      mem_op,
                         addr:    alu_result,
                         data:    store_data,
                         wb_en:   wb_en_in,
                         wb_addr: wb_addr_in};
              cnt   <= '0;
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Ack takes priority over an expiring timeout.
          if (dmem_ack) begin
            out_valid    <= 1'b1;
            wb_data      <= st_q ? req_q.addr : ld_data;
            wb_en        <= !st_q && req_q.wb_en;
            wb_addr      <= req_q.wb_addr;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b0;
            state        <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            out_valid    <= 1'b1;
            wb_data      <= req_q.addr;
            wb_en        <= 1'b0;
            wb_addr      <= req_q.wb_addr;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus
// randomized ops against a behavioural reference model.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [3:0]  mem_op = '0;
  logic        wb_en_in = 1'b0;
  logic [4:0]  wb_addr_in = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        out_valid;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic        exc_misalign, exc_bus;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_op       (mem_op),
    .wb_en_in     (wb_en_in),
    .wb_addr_in   (wb_addr_in),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .out_valid    (out_valid),
    .wb_data      (wb_data),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .exc_misalign (exc_misalign),
    .exc_bus      (exc_bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model, plain arithmetic on the op table.
  function automatic bit m_load(input int op);
    return op >= 1 && op <= 5;
  endfunction

  function automatic bit m_store(input int op);
    return op >= 6 && op <= 8;
  endfunction

  function automatic bit m_mis(input int op, input int a);
    if (op == 3 || op == 4 || op == 7) return (a % 2) != 0;
    if (op == 5 || op == 8) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input int op, input int a);
    if (op == 6) return 4'(1 << (a % 4));
    if (op == 7) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int op,
                                          input logic [31:0] d);
    if (op == 6) return (d & 32'hFF) * 32'h0101_0101;
    if (op == 7) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input int op, input int a,
                                       input logic [31:0] rd);
    logic [31:0] v;
    if (op == 1 || op == 2) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (op == 1 && v >= 32'd128) v = v - 32'd256;
    end else if (op == 3 || op == 4) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (op == 3 && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Drives one instruction and checks it through to write-back.
  // ackd: index of the req cycle in which ack is returned.
  task automatic run_op(input int op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic wbe,
                        input logic [4:0] wba, input int ackd,
                        input logic [31:0] rd);
    int a;
    bit mem, mis, done;
    a    = int'(addr[1:0]);
    mem  = m_load(op) || m_store(op);
    mis  = mem && m_mis(op, a);
    done = 1'b0;
    chk("in_ready_idle", in_ready, 1);
    in_valid   = 1'b1;
    mem_op     = 4'(op);
    alu_result = addr;
    store_data = sd;
    wb_en_in   = wbe;
    wb_addr_in = wba;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!mem || mis) begin
      chk("ov", out_valid, 1);
      chk("no_req", dmem_req, 0);
      chk("exc_mis", exc_misalign, 32'(mis));
      chk("exc_bus", exc_bus, 0);
      chk("wb_en", wb_en, mis ? 0 : 32'(wbe));
      chk("wb_addr", wb_addr, 32'(wba));
      if (!mis) chk("wb_data", wb_data, addr);
    end else begin
      for (int i = 0; i < TMO && !done; i++) begin
        chk("req", dmem_req, 1);
        chk("in_ready_busy", in_ready, 0);
        chk("ov_busy", out_valid, 0);
        chk("daddr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("be", dmem_be, m_be(op, a));
        chk("we", dmem_we, 32'(m_store(op)));
        if (m_store(op)) chk("wdata", dmem_wdata, m_wdata(op, sd));
        if (i == ackd) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rd;
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        if (i == ackd) done = 1'b1;
      end
      chk("ov_done", out_valid, 1);
      chk("in_ready_done", in_ready, 1);
      chk("req_done", dmem_req, 0);
      chk("exc_bus", exc_bus, 32'(!done));
      chk("exc_mis", exc_misalign, 0);
      chk("wb_addr", wb_addr, 32'(wba));
      chk("wb_en", wb_en, (done && m_load(op)) ? 32'(wbe) : 0);
      if (done && m_load(op))
        chk("ld_data", wb_data, m_ld(op, a, rd));
    end
    @(posedge clk); #1;
    chk("ov_pulse", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_exc", {exc_misalign, exc_bus}, 0);
    chk("rst_req", {dmem_req, dmem_we, dmem_be}, 0);
    chk("rst_daddr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;

    run_op(0, 32'h1234_5678, 0, 1'b1, 5'd3, 0, 0);
    run_op(1, 32'h0000_0103, 0, 1'b1, 5'd7, 3, 32'h80FF_0000);
    run_op(2, 32'h0000_0103, 0, 1'b1, 5'd7, 3, 32'h80FF_0000);
    run_op(7, 32'h0000_0202, 32'hAAAA_BEEF, 1'b1, 5'd9, 0, 0);
    run_op(5, 32'h0000_0006, 0, 1'b1, 5'd4, 0, 0);
    run_op(5, 32'h0000_0040, 0, 1'b1, 5'd5, 99, 0);
    run_op(5, 32'h0000_0044, 0, 1'b1, 5'd6, TMO - 1,
           32'hCAFE_F00D);

    // Back-to-back pass-through ops, one per cycle.
    in_valid = 1'b1;
    mem_op   = 4'd0;
    wb_en_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      alu_result = 32'h100 + 32'(k);
      wb_addr_in = 5'(k + 1);
      @(posedge clk); #1;
      chk("b2b_ov", out_valid, 1);
      chk("b2b_data", wb_data, 32'h100 + 32'(k));
      chk("b2b_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while a transaction is in flight.
    in_valid   = 1'b1;
    mem_op     = 4'd5;
    alu_result = 32'h0000_0080;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_req", dmem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_acc_req", dmem_req, 0);
    chk("rst_acc_ov", out_valid, 0);
    chk("rst_acc_ready", in_ready, 1);
    rst      = 1'b0;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_ov", out_valid, 0);
    @(posedge clk); #1;
    chk("late_ack_ov2", out_valid, 0);

    for (int n = 0; n < 60; n++) begin
      run_op(int'($urandom_range(0, 15)), $urandom, $urandom,
             1'($urandom), 5'($urandom), int'($urandom_range(0, 5)),
             $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. Accepts the ALU result, store operand, memory opcode and write-back tag; performs byte/half/word loads and stores through a req/ack data-memory port; produces a registered MEM/WB bundle. While a memory transaction is in flight it holds the upstream pipeline off.

## Interface

- `TIMEOUT`, default 255: cycles `dmem_req` may stay unacknowledged before a bus error is raised (1..65535).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  an instruction from execute is presented.
- `in_ready`  out  1  stage can accept; `in_valid` with `in_ready` low is held by upstream.
- `alu_result`  in  32  effective address for memory ops, result otherwise.
- `store_data`  in  32  rt value for stores.
- `mem_op`  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as NONE.
- `wb_en_in`  in  1  write-back enable.
- `wb_addr_in`  in  5  destination register.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  write request.
- `dmem_addr`  out  32  word address, bits [1:0] always 0.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rdata`  in  32  read word, valid with `dmem_ack`.
- `dmem_ack`  in  1  transaction complete.
- `out_valid`  out  1  MEM/WB bundle valid, one-cycle pulse per instruction.
- `wb_data`  out  32  load result or passed-through `alu_result`.
- `wb_en`  out  1  write-back enable (forced 0 on any exception).
- `wb_addr`  out  5  destination register.
- `exc_misalign`  out  1  misaligned address.
- `exc_bus`  out  1  memory timeout.

## Operation

- FSM states IDLE, ACCESS. `in_ready` = (state == IDLE), combinational.
- IDLE, `in_valid`, NONE op: next edge registers `out_valid`=1, `wb_data`=`alu_result`, `wb_en`/`wb_addr` from inputs; remain IDLE.
- IDLE, `in_valid`, memory op misaligned (half with addr[0]=1; word with addr[1:0]≠0): next edge `out_valid`=1, `exc_misalign`=1, `wb_en`=0; no memory request; remain IDLE.
- IDLE, `in_valid`, aligned memory op: latch op, address, data, tag; go to ACCESS; clear timeout counter.
- ACCESS: `dmem_req`=1, `dmem_addr`={addr[31:2],2'b00}, `dmem_we`=store. Byte lanes little-endian: lane k = bits [8k+7:8k] = byte at addr[1:0]=k. SB be=1<<addr[1:0], wdata={4{byte}}; SH be=0011/1100, wdata={2{half}}; SW be=1111. Loads be=1111.
- ACCESS, `dmem_ack`: load lane selected by latched addr, sign-extended (LB, LH) or zero-extended (LBU, LHU); next edge `out_valid`=1, stores `wb_en`=0; return IDLE.
- ACCESS, no ack: counter increments; when counter reaches `TIMEOUT` without ack, next edge `out_valid`=1, `exc_bus`=1, `wb_en`=0, return IDLE. Ack on that same cycle wins over timeout.
- Idle outputs: `dmem_*` all 0 outside ACCESS. `dmem_ack` in IDLE ignored.

## Timing

- Reset: state IDLE, counter 0; `out_valid`, `wb_en`, `exc_*`, `dmem_req`, `dmem_we` = 0; `wb_data`, `dmem_addr`, `dmem_wdata` = 0; `wb_addr` = 0; `dmem_be` = 0. Reset in ACCESS abandons the transaction; `dmem_req` low the cycle after the reset edge.
- Non-memory/misaligned latency: 1 cycle; back-to-back accepted every cycle.
- Memory latency: accept edge N; `dmem_req` high from N; ack sampled at edge M≥N+1; `out_valid` high after M; next instruction accepted at M+1 earliest (`in_ready` high from M).
- `out_valid` and bundle fields are registered; bundle holds until next update.

## Structure

- Shared package `mips_pkg`: `mem_op` encoding constants, `MEM_NONE`..`MEM_SW`.
- One sub-module: `load_align` (combinational lane select + sign/zero extend); store lane formatting stays inline.

## Test plan

- ALU pass-through: NONE, `alu_result`=0x1234_5678, wb_addr=3 → next cycle `out_valid`=1, `wb_data`=0x1234_5678, `wb_en`=1, no `dmem_req`.
- LB addr 0x103, rdata 0x80FF_0000, ack after 3 cycles → `dmem_addr`=0x100, `wb_data`=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH addr 0x202, data 0xAAAA_BEEF, ack same cycle → `dmem_be`=1100, `dmem_wdata`=0xBEEF_BEEF, `dmem_we`=1, `wb_en`=0.
- LW addr 0x6 → `exc_misalign`=1, `wb_en`=0, `dmem_req` never asserted.
- TIMEOUT=4, LW with no ack → `exc_bus` with `out_valid` after 4 cycles of req; `in_ready` high next cycle.
- `rst` asserted in ACCESS → next cycle `dmem_req`=0, `out_valid`=0; late ack ignored, no `out_valid`.
